// File: rtl/perf_event_collector_if.sv
// Dump-control and record-stream bundle of perf_event_collector.
// master: the collector (drives records); slave: the consumer.
interface perf_event_collector_if #(
    parameter int EVENT_NUM = 8,
    parameter int CNT_WIDTH = 32
);
    localparam int ID_W = $clog2(EVENT_NUM);

    logic                 dump_req_i;
    logic                 dump_busy_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [ID_W-1:0]      out_id_o;
    logic [CNT_WIDTH-1:0] out_cnt_o;
    logic                 out_last_o;

    modport master (
        input  dump_req_i, out_ready_i,
        output dump_busy_o, out_valid_o, out_id_o, out_cnt_o, out_last_o
    );

    modport slave (
        output dump_req_i, out_ready_i,
        input  dump_busy_o, out_valid_o, out_id_o, out_cnt_o, out_last_o
    );
endinterface

// File: rtl/perf_event_collector.sv
// Per-event counters with snapshot-and-serialize dump over a valid/ready stream.
// Build option: define PERF_COUNTER_SAT_EN for saturating counters (default wraps).
module perf_event_collector #(
    parameter int EVENT_NUM = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EVENT_NUM-1:0] event_i,
    input  logic                 clear_i,
    perf_event_collector_if.master bus
);
    localparam int ID_W = $clog2(EVENT_NUM);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(EVENT_NUM - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] live_q   [EVENT_NUM];
    logic [CNT_WIDTH-1:0] live_d   [EVENT_NUM];
    logic [CNT_WIDTH-1:0] shadow_q [EVENT_NUM];
    logic [CNT_WIDTH-1:0] shadow_d [EVENT_NUM];
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 last_q, last_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]      id_nxt;

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
`ifdef PERF_COUNTER_SAT_EN
        cnt_inc = (&v) ? v : v + 1'b1;
`else
        cnt_inc = v + 1'b1;
`endif
    endfunction

    assign id_nxt = id_q + 1'b1;

    always_comb begin
        for (int unsigned i = 0; i < EVENT_NUM; i++) begin
            if (clear_i)
                live_d[i] = '0;
            else if (event_i[i])
                live_d[i] = cnt_inc(live_q[i]);
            else
                live_d[i] = live_q[i];
        end

        shadow_d = shadow_q;
        state_d  = state_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        last_d   = last_q;
        id_d     = id_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.dump_req_i) begin
                    // Snapshot takes this cycle's register values, before increment/clear.
                    shadow_d = live_q;
                    state_d  = SEND;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    id_d     = '0;
                    cnt_d    = live_q[0];
                    last_d   = 1'b0;
                end
            end
            SEND: begin
                if (valid_q && bus.out_ready_i) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        id_d    = '0;
                        cnt_d   = '0;
                    end else begin
                        id_d   = id_nxt;
                        cnt_d  = shadow_q[id_nxt];
                        last_d = (id_nxt == LAST_ID);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < EVENT_NUM; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.out_valid_o = valid_q;
    assign bus.dump_busy_o = busy_q;
    assign bus.out_last_o  = last_q;
    assign bus.out_id_o    = id_q;
    assign bus.out_cnt_o   = cnt_q;
endmodule
